mem_bank_port_arbiter: RTL and testbench



---
 rtl/mem_bank_port_arbiter_if.sv | 47 ++++
 rtl/mem_bank_port_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_mem_bank_port_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bank_port_arbiter_if.sv
// Port-side and memory-side bus of the bank port arbiter.
// Port-side vectors are flattened with index [p*NumBanks+b]; memory-side with index [b].
interface mem_bank_port_arbiter_if #(
    parameter int unsigned NumPorts      = 2,
    parameter int unsigned NumBanks      = 4,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned BankDataWidth = 32
);
    localparam int unsigned StrbWidth = BankDataWidth / 8;
    localparam int unsigned NumReq    = NumPorts * NumBanks;

    logic [NumReq-1:0]                 port_req_i;
    logic [NumReq-1:0]                 port_gnt_o;
    logic [NumReq*AddrWidth-1:0]       port_addr_i;
    logic [NumReq*BankDataWidth-1:0]   port_wdata_i;
    logic [NumReq*StrbWidth-1:0]       port_strb_i;
    logic [NumReq-1:0]                 port_we_i;
    logic [NumReq*6-1:0]               port_atop_i;
    logic [NumReq-1:0]                 port_rvalid_o;
    logic [NumReq*BankDataWidth-1:0]   port_rdata_o;

    logic [NumBanks-1:0]               mem_req_o;
    logic [NumBanks-1:0]               mem_gnt_i;
    logic [NumBanks*AddrWidth-1:0]     mem_addr_o;
    logic [NumBanks*BankDataWidth-1:0] mem_wdata_o;
    logic [NumBanks*StrbWidth-1:0]     mem_strb_o;
    logic [NumBanks-1:0]               mem_we_o;
    logic [NumBanks*6-1:0]             mem_atop_o;
    logic [NumBanks-1:0]               mem_rvalid_i;
    logic [NumBanks*BankDataWidth-1:0] mem_rdata_i;

    // Arbiter view.
    modport slave (
        input  port_req_i, port_addr_i, port_wdata_i, port_strb_i, port_we_i, port_atop_i,
        output port_gnt_o, port_rvalid_o, port_rdata_o,
        output mem_req_o, mem_addr_o, mem_wdata_o, mem_strb_o, mem_we_o, mem_atop_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    // Environment view: masters plus memory.
    modport master (
        output port_req_i, port_addr_i, port_wdata_i, port_strb_i, port_we_i, port_atop_i,
        input  port_gnt_o, port_rvalid_o, port_rdata_o,
        input  mem_req_o, mem_addr_o, mem_wdata_o, mem_strb_o, mem_we_o, mem_atop_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );
endinterface

// File: rtl/mem_bank_port_arbiter.sv
// N-port to banked-SRAM arbiter: per-bank selection (round robin or fixed priority
// with aging), routing FIFO steering responses back to the winning port, and a
// sticky flag for responses that arrive with nothing outstanding.
module mem_bank_port_arbiter #(
    parameter int unsigned NumPorts      = 2,
    parameter int unsigned NumBanks      = 4,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned BankDataWidth = 32,
    parameter int unsigned BufDepth      = 1,
    parameter int unsigned ArbMode       = 0,
    parameter int unsigned StarveLimit   = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic busy_o,
    output logic err_o,
    mem_bank_port_arbiter_if.slave bus
);
    localparam int unsigned StrbWidth = BankDataWidth / 8;
    localparam int unsigned PortIdxW  = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int unsigned FifoDepth = BufDepth + 1;
    localparam int unsigned FifoPtrW  = $clog2(FifoDepth);
    localparam int unsigned CntW      = $clog2(FifoDepth + 1);
    localparam int unsigned AgeW      = $clog2(StarveLimit + 1);

    typedef logic [PortIdxW-1:0] port_idx_t;
    typedef logic [FifoPtrW-1:0] fifo_ptr_t;

    port_idx_t           ptr_q [NumBanks];
    port_idx_t           ptr_d [NumBanks];
    logic [AgeW-1:0]     age_q [NumBanks];
    logic [AgeW-1:0]     age_d [NumBanks];
    logic [NumBanks-1:0] lock_q, lock_d;
    port_idx_t           lock_sel_q [NumBanks];
    port_idx_t           lock_sel_d [NumBanks];
    port_idx_t           fifo_q [NumBanks][FifoDepth];
    port_idx_t           fifo_d [NumBanks][FifoDepth];
    fifo_ptr_t           wr_ptr_q [NumBanks];
    fifo_ptr_t           wr_ptr_d [NumBanks];
    fifo_ptr_t           rd_ptr_q [NumBanks];
    fifo_ptr_t           rd_ptr_d [NumBanks];
    logic [CntW-1:0]     cnt_q [NumBanks];
    logic [CntW-1:0]     cnt_d [NumBanks];
    logic                err_q, err_d;

    port_idx_t           sel [NumBanks];
    logic [NumBanks-1:0] any_req, contended, full, empty, mem_req, hs, pop, orphan;

    function automatic fifo_ptr_t ptr_inc(input fifo_ptr_t p);
        return (p == FifoPtrW'(FifoDepth - 1)) ? '0 : p + FifoPtrW'(1);
    endfunction

    // Per-bank port selection: a stalled request keeps its winner, otherwise RR or priority.
    always_comb begin
        int unsigned ncand;
        int unsigned idx;
        logic        rr_found, fp_found, use_rr;
        port_idx_t   rr_sel, fp_sel;
        ncand     = 0;
        idx       = 0;
        rr_found  = 1'b0;
        fp_found  = 1'b0;
        use_rr    = 1'b0;
        rr_sel    = '0;
        fp_sel    = '0;
        sel       = '{default: '0};
        any_req   = '0;
        contended = '0;
        for (int unsigned b = 0; b < NumBanks; b++) begin
            ncand    = 0;
            rr_found = 1'b0;
            fp_found = 1'b0;
            rr_sel   = '0;
            fp_sel   = '0;
            for (int unsigned p = 0; p < NumPorts; p++) begin
                if (bus.port_req_i[p*NumBanks+b]) begin
                    ncand = ncand + 1;
                    if (!fp_found) begin
                        fp_sel   = PortIdxW'(p);
                        fp_found = 1'b1;
                    end
                end
            end
            for (int unsigned i = 0; i < NumPorts; i++) begin
                idx = (32'(ptr_q[b]) + i) % NumPorts;
                if (!rr_found && bus.port_req_i[idx*NumBanks+b]) begin
                    rr_sel   = PortIdxW'(idx);
                    rr_found = 1'b1;
                end
            end
            // Aging hands one grant to round robin once the limit is reached.
            use_rr       = (ArbMode == 0) || (age_q[b] == AgeW'(StarveLimit));
            any_req[b]   = (ncand != 0);
            contended[b] = (ncand > 1);
            if (lock_q[b] && bus.port_req_i[32'(lock_sel_q[b])*NumBanks+b]) begin
                sel[b] = lock_sel_q[b];
            end else if (use_rr) begin
                sel[b] = rr_sel;
            end else begin
                sel[b] = fp_sel;
            end
        end
    end

    // FIFO status; a full FIFO blocks requests even when a pop happens this cycle.
    always_comb begin
        full  = '0;
        empty = '0;
        for (int unsigned b = 0; b < NumBanks; b++) begin
            full[b]  = (cnt_q[b] == CntW'(FifoDepth));
            empty[b] = (cnt_q[b] == '0);
        end
    end

    assign mem_req = any_req & ~full & {NumBanks{~rst_i}};
    assign hs      = mem_req & bus.mem_gnt_i;
    assign pop     = bus.mem_rvalid_i & ~empty;
    assign orphan  = bus.mem_rvalid_i & empty;
    assign busy_o  = (|mem_req) | (|(~empty));
    assign err_o   = err_q;

    // Request mux, grant decode and response steering.
    always_comb begin
        int unsigned k;
        k                  = 0;
        bus.port_gnt_o     = '0;
        bus.port_rvalid_o  = '0;
        bus.port_rdata_o   = '0;
        bus.mem_req_o      = mem_req;
        bus.mem_addr_o     = '0;
        bus.mem_wdata_o    = '0;
        bus.mem_strb_o     = '0;
        bus.mem_we_o       = '0;
        bus.mem_atop_o     = '0;
        for (int unsigned b = 0; b < NumBanks; b++) begin
            k = 32'(sel[b]) * NumBanks + b;
            bus.mem_addr_o[b*AddrWidth +: AddrWidth]         = bus.port_addr_i[k*AddrWidth +: AddrWidth];
            bus.mem_wdata_o[b*BankDataWidth +: BankDataWidth] =
                bus.port_wdata_i[k*BankDataWidth +: BankDataWidth];
            bus.mem_strb_o[b*StrbWidth +: StrbWidth]         = bus.port_strb_i[k*StrbWidth +: StrbWidth];
            bus.mem_we_o[b]                                  = bus.port_we_i[k];
            bus.mem_atop_o[b*6 +: 6]                         = bus.port_atop_i[k*6 +: 6];
            bus.port_gnt_o[k]                                = hs[b];
            bus.port_rvalid_o[32'(fifo_q[b][rd_ptr_q[b]])*NumBanks+b] = pop[b];
            for (int unsigned p = 0; p < NumPorts; p++) begin
                bus.port_rdata_o[(p*NumBanks+b)*BankDataWidth +: BankDataWidth] =
                    bus.mem_rdata_i[b*BankDataWidth +: BankDataWidth];
            end
        end
    end

    // Next state: pointers, aging, lock, routing FIFO and error flag.
    always_comb begin
        ptr_d      = ptr_q;
        age_d      = age_q;
        lock_d     = mem_req & ~bus.mem_gnt_i;
        lock_sel_d = sel;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        err_d      = err_q | (|orphan);
        for (int unsigned b = 0; b < NumBanks; b++) begin
            if (hs[b]) begin
                ptr_d[b] = (32'(sel[b]) == NumPorts - 1) ? '0 : sel[b] + PortIdxW'(1);
                fifo_d[b][wr_ptr_q[b]] = sel[b];
                wr_ptr_d[b] = ptr_inc(wr_ptr_q[b]);
                if (ArbMode != 0) begin
                    if (age_q[b] == AgeW'(StarveLimit) || !contended[b]) begin
                        age_d[b] = '0;
                    end else begin
                        age_d[b] = age_q[b] + AgeW'(1);
                    end
                end
            end
            if (pop[b]) begin
                rd_ptr_d[b] = ptr_inc(rd_ptr_q[b]);
            end
            if (hs[b] && !pop[b]) begin
                cnt_d[b] = cnt_q[b] + CntW'(1);
            end else if (!hs[b] && pop[b]) begin
                cnt_d[b] = cnt_q[b] - CntW'(1);
            end
        end
    end

    // State registers; reset discards all routing state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q      <= '{default: '0};
            age_q      <= '{default: '0};
            lock_q     <= '0;
            lock_sel_q <= '{default: '0};
            wr_ptr_q   <= '{default: '0};
            rd_ptr_q   <= '{default: '0};
            cnt_q      <= '{default: '0};
            err_q      <= 1'b0;
            for (int unsigned b = 0; b < NumBanks; b++) begin
                for (int unsigned e = 0; e < FifoDepth; e++) begin
                    fifo_q[b][e] <= '0;
                end
            end
        end else begin
            ptr_q      <= ptr_d;
            age_q      <= age_d;
            lock_q     <= lock_d;
            lock_sel_q <= lock_sel_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_mem_bank_port_arbiter.sv
// Randomised scoreboard bench: one round-robin and one fixed-priority instance share
// stimulus; fp_mode selects which one is checked against the reference model.
module tb_mem_bank_port_arbiter;
    localparam int NP = 3, NB = 4, AW = 32, DW = 32, SW = 4, BD = 1, DEPTH = BD + 1, LIM = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NP*NB-1:0]    port_req = '0, port_we = '0;
    logic [NP*NB*AW-1:0] port_addr = '0;
    logic [NP*NB*DW-1:0] port_wdata = '0;
    logic [NP*NB*SW-1:0] port_strb = '0;
    logic [NP*NB*6-1:0]  port_atop = '0;
    logic [NB-1:0]       mem_gnt = '0, mem_rvalid = '0;
    logic [NB*DW-1:0]    mem_rdata = '0;

    mem_bank_port_arbiter_if #(.NumPorts(NP), .NumBanks(NB), .AddrWidth(AW), .BankDataWidth(DW))
        bus_rr ();
    mem_bank_port_arbiter_if #(.NumPorts(NP), .NumBanks(NB), .AddrWidth(AW), .BankDataWidth(DW))
        bus_fp ();
    logic busy_rr, err_rr, busy_fp, err_fp;

    assign bus_rr.port_req_i = port_req;     assign bus_fp.port_req_i = port_req;
    assign bus_rr.port_addr_i = port_addr;   assign bus_fp.port_addr_i = port_addr;
    assign bus_rr.port_wdata_i = port_wdata; assign bus_fp.port_wdata_i = port_wdata;
    assign bus_rr.port_strb_i = port_strb;   assign bus_fp.port_strb_i = port_strb;
    assign bus_rr.port_we_i = port_we;       assign bus_fp.port_we_i = port_we;
    assign bus_rr.port_atop_i = port_atop;   assign bus_fp.port_atop_i = port_atop;
    assign bus_rr.mem_gnt_i = mem_gnt;       assign bus_fp.mem_gnt_i = mem_gnt;
    assign bus_rr.mem_rvalid_i = mem_rvalid; assign bus_fp.mem_rvalid_i = mem_rvalid;
    assign bus_rr.mem_rdata_i = mem_rdata;   assign bus_fp.mem_rdata_i = mem_rdata;

    mem_bank_port_arbiter #(.NumPorts(NP), .NumBanks(NB), .AddrWidth(AW), .BankDataWidth(DW),
        .BufDepth(BD), .ArbMode(0), .StarveLimit(LIM)) dut_rr (
        .clk_i(clk), .rst_i(rst), .busy_o(busy_rr), .err_o(err_rr), .bus(bus_rr));
    mem_bank_port_arbiter #(.NumPorts(NP), .NumBanks(NB), .AddrWidth(AW), .BankDataWidth(DW),
        .BufDepth(BD), .ArbMode(1), .StarveLimit(LIM)) dut_fp (
        .clk_i(clk), .rst_i(rst), .busy_o(busy_fp), .err_o(err_fp), .bus(bus_fp));

    bit fp_mode = 1'b0;
    logic [NP*NB-1:0]    gnt_s, rvalid_s;
    logic [NP*NB*DW-1:0] rdata_s;
    logic [NB-1:0]       mreq_s, mwe_s;
    logic [NB*AW-1:0]    maddr_s;
    logic [NB*DW-1:0]    mwdata_s;
    logic [NB*SW-1:0]    mstrb_s;
    logic [NB*6-1:0]     matop_s;
    logic                busy_s, err_s;
    assign gnt_s    = fp_mode ? bus_fp.port_gnt_o    : bus_rr.port_gnt_o;
    assign rvalid_s = fp_mode ? bus_fp.port_rvalid_o : bus_rr.port_rvalid_o;
    assign rdata_s  = fp_mode ? bus_fp.port_rdata_o  : bus_rr.port_rdata_o;
    assign mreq_s   = fp_mode ? bus_fp.mem_req_o     : bus_rr.mem_req_o;
    assign maddr_s  = fp_mode ? bus_fp.mem_addr_o    : bus_rr.mem_addr_o;
    assign mwdata_s = fp_mode ? bus_fp.mem_wdata_o   : bus_rr.mem_wdata_o;
    assign mstrb_s  = fp_mode ? bus_fp.mem_strb_o    : bus_rr.mem_strb_o;
    assign mwe_s    = fp_mode ? bus_fp.mem_we_o      : bus_rr.mem_we_o;
    assign matop_s  = fp_mode ? bus_fp.mem_atop_o    : bus_rr.mem_atop_o;
    assign busy_s   = fp_mode ? busy_fp : busy_rr;
    assign err_s    = fp_mode ? err_fp  : err_rr;

    // Reference model state.
    int ptr [NB], age [NB], lock_p [NB], occ [NB];
    bit granted [NP][NB];
    bit rv_issue [NB];
    bit exp_err;
    int sb_port [NB][$];
    logic [DW-1:0] sb_data [NB][$];
    logic [DW-1:0] pend [NB][$];

    int vectors = 0, miscompares = 0;
    int density, gnt_prob, rv_prob;

    task automatic report(input string name, input bit ok, input logic [127:0] act,
                          input logic [127:0] exp);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear(input bit keep_pend);
        for (int b = 0; b < NB; b++) begin
            ptr[b] = 0; age[b] = 0; lock_p[b] = -1; occ[b] = 0; rv_issue[b] = 1'b0;
            sb_port[b].delete();
            sb_data[b].delete();
            if (!keep_pend) pend[b].delete();
            for (int p = 0; p < NP; p++) granted[p][b] = 1'b0;
        end
        exp_err = 1'b0;
    endtask

    // Masters hold request and payload until granted; memory answers in order, >=1 cycle late.
    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            for (int b = 0; b < NB; b++) begin
                int k;
                k = p * NB + b;
                if (!(port_req[k] && !granted[p][b])) begin
                    granted[p][b] = 1'b0;
                    if ($urandom_range(99) < density) begin
                        port_req[k] = 1'b1;
                        port_addr[k*AW +: AW]  = $urandom;
                        port_wdata[k*DW +: DW] = $urandom;
                        port_strb[k*SW +: SW]  = 4'($urandom_range(15));
                        port_we[k]             = 1'($urandom_range(1));
                        port_atop[k*6 +: 6]    = 6'($urandom_range(63));
                    end else begin
                        port_req[k] = 1'b0;
                    end
                end
            end
        end
        for (int b = 0; b < NB; b++) begin
            mem_gnt[b] = ($urandom_range(99) < gnt_prob);
            if (pend[b].size() > 0 && $urandom_range(99) < rv_prob) begin
                mem_rvalid[b] = 1'b1;
                mem_rdata[b*DW +: DW] = pend[b].pop_front();
                rv_issue[b] = 1'b1;
            end else begin
                mem_rvalid[b] = 1'b0;
                mem_rdata[b*DW +: DW] = $urandom;
                rv_issue[b] = 1'b0;
            end
        end
    endtask

    // Expected request/grant/payload per bank from the arbitration rules, then model update.
    task automatic check_cycle();
        int sel [NB];
        int ncand [NB];
        bit hs [NB];
        bit any_req, any_occ;
        any_req = 1'b0;
        any_occ = 1'b0;
        for (int b = 0; b < NB; b++) begin
            bit exp_req;
            logic [NP-1:0] eg, ag;
            logic [78:0] a, e;
            int k, q;
            ncand[b] = 0;
            sel[b] = -1;
            for (int p = 0; p < NP; p++) if (port_req[p*NB+b]) ncand[b]++;
            exp_req = (ncand[b] > 0) && (occ[b] < DEPTH);
            if (ncand[b] > 0) begin
                if (lock_p[b] >= 0 && port_req[lock_p[b]*NB+b]) begin
                    sel[b] = lock_p[b];
                end else if (!fp_mode || age[b] == LIM) begin
                    for (int i = 0; i < NP; i++) begin
                        q = (ptr[b] + i) % NP;
                        if (sel[b] < 0 && port_req[q*NB+b]) sel[b] = q;
                    end
                end else begin
                    for (int p = 0; p < NP; p++) if (sel[b] < 0 && port_req[p*NB+b]) sel[b] = p;
                end
            end
            hs[b] = exp_req && mem_gnt[b];
            eg = '0;
            if (hs[b]) eg[sel[b]] = 1'b1;
            for (int p = 0; p < NP; p++) ag[p] = gnt_s[p*NB+b];
            a = '0;
            e = '0;
            a[78] = mreq_s[b];
            e[78] = exp_req;
            a[77:75] = ag;
            e[77:75] = eg;
            if (exp_req) begin
                k = sel[b] * NB + b;
                e[74:0] = {port_addr[k*AW +: AW], port_wdata[k*DW +: DW], port_strb[k*SW +: SW],
                           port_we[k], port_atop[k*6 +: 6]};
                a[74:0] = {maddr_s[b*AW +: AW], mwdata_s[b*DW +: DW], mstrb_s[b*SW +: SW],
                           mwe_s[b], matop_s[b*6 +: 6]};
            end
            report($sformatf("bank%0d_req_gnt_payload", b), a == e, 128'(a), 128'(e));
            any_req |= exp_req;
            any_occ |= (occ[b] > 0);
        end
        report("busy", busy_s == (any_req || any_occ), 128'(busy_s), 128'(any_req || any_occ));
        report("err", err_s == exp_err, 128'(err_s), 128'(exp_err));
        for (int b = 0; b < NB; b++) begin
            int occ_pre;
            occ_pre = occ[b];
            if (hs[b]) begin
                logic [DW-1:0] d;
                d = $urandom;
                sb_port[b].push_back(sel[b]);
                sb_data[b].push_back(d);
                pend[b].push_back(d);
                ptr[b] = (sel[b] + 1) % NP;
                if (fp_mode) age[b] = (age[b] == LIM || ncand[b] < 2) ? 0 : age[b] + 1;
                lock_p[b] = -1;
                granted[sel[b]][b] = 1'b1;
                occ[b]++;
            end else if (ncand[b] > 0 && occ_pre < DEPTH) begin
                lock_p[b] = sel[b];
            end else begin
                lock_p[b] = -1;
            end
            if (rv_issue[b]) begin
                if (occ_pre > 0) occ[b]--;
                else exp_err = 1'b1;
            end
        end
    endtask

    task automatic run_cycles(input int n, input int dens, input int gp, input int rp);
        density = dens;
        gnt_prob = gp;
        rv_prob = rp;
        repeat (n) begin
            @(posedge clk);
            #1;
            drive();
            @(negedge clk);
            check_cycle();
        end
    endtask

    // Asynchronous reset with requests still raised: outputs must drop at once.
    task automatic do_reset(input bit keep_pend);
        #1 rst = 1'b1;
        #1;
        report("reset_mem_req", mreq_s == '0, 128'(mreq_s), 128'(0));
        report("reset_gnt", gnt_s == '0, 128'(gnt_s), 128'(0));
        report("reset_rvalid", rvalid_s == '0, 128'(rvalid_s), 128'(0));
        report("reset_busy", busy_s == 1'b0, 128'(busy_s), 128'(0));
        report("reset_err", err_s == 1'b0, 128'(err_s), 128'(0));
        port_req = '0;
        mem_gnt = '0;
        mem_rvalid = '0;
        model_clear(keep_pend);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Monitor: every response the DUT presents is matched against the scoreboard head.
    int mon_n, mon_port;
    bit mon_ok;
    always @(negedge clk) begin
        for (int b = 0; b < NB; b++) begin
            mon_n = 0;
            mon_port = -1;
            for (int p = 0; p < NP; p++) begin
                if (rvalid_s[p*NB+b]) begin
                    mon_n++;
                    mon_port = p;
                end
            end
            if (mon_n > 0) begin
                if (sb_port[b].size() == 0) begin
                    report($sformatf("bank%0d_unexpected_rvalid", b), 1'b0,
                           128'(rvalid_s), 128'(0));
                end else begin
                    int ep;
                    logic [DW-1:0] ed;
                    ep = sb_port[b].pop_front();
                    ed = sb_data[b].pop_front();
                    mon_ok = (mon_n == 1) && (mon_port == ep);
                    for (int p = 0; p < NP; p++) mon_ok &= (rdata_s[(p*NB+b)*DW +: DW] == ed);
                    report($sformatf("bank%0d_response", b), mon_ok,
                           {64'(mon_port), 32'(mon_n), rdata_s[(mon_port*NB+b)*DW +: DW]},
                           {64'(ep), 32'(1), ed});
                end
            end
        end
    end

    initial begin
        model_clear(1'b0);
        #2;
        report("por_mem_req", mreq_s == '0, 128'(mreq_s), 128'(0));
        report("por_busy", busy_s == 1'b0, 128'(busy_s), 128'(0));
        report("por_err", err_s == 1'b0, 128'(err_s), 128'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        // Round robin: saturated, random, FIFO-full backpressure, drain.
        run_cycles(30, 100, 100, 100);
        run_cycles(400, 60, 50, 60);
        run_cycles(6, 100, 100, 0);
        run_cycles(6, 100, 100, 100);
        run_cycles(20, 0, 100, 100);

        // Orphan response on bank 1: dropped, err sticks until reset.
        pend[1].push_back(32'hA5A5_A5A5);
        run_cycles(12, 0, 100, 100);
        do_reset(1'b0);

        // Reset with responses outstanding: late responses become orphans.
        run_cycles(3, 100, 100, 0);
        do_reset(1'b1);
        run_cycles(8, 0, 100, 100);
        do_reset(1'b0);

        // Fixed priority with aging.
        fp_mode = 1'b1;
        do_reset(1'b0);
        run_cycles(40, 100, 100, 100);
        run_cycles(400, 60, 50, 60);
        run_cycles(6, 100, 100, 0);
        run_cycles(30, 0, 100, 100);

        @(posedge clk);
        #1;
        for (int b = 0; b < NB; b++) begin
            report($sformatf("bank%0d_drained", b), sb_port[b].size() == 0,
                   128'(sb_port[b].size()), 128'(0));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
